// File: rtl/cop0_intctl_if.sv
// Bus between the COP0 interrupt controller and its surroundings: raw
// hardware requests, mask/enable state, software strobes and acknowledge
// go in; pending vector, request, vector and lost-edge count come out.
interface cop0_intctl_if #(
   parameter int N_HW  = 6,
   parameter int N_SW  = 2,
   parameter int VEC_W = 3,
   parameter int CNT_W = 8
);
   logic [N_HW-1:0]      INTREQN;
   logic [N_HW-1:0]      CFG_EDGE;
   logic [N_HW+N_SW-1:0] CP0_IM_W_R;
   logic                 IEC_W_R;
   logic                 CP0_JCTRLDM_M_R;
   logic                 CLMI_RHOLD;
   logic [N_SW-1:0]      SWSET_W;
   logic [N_SW-1:0]      SWCLR_W;
   logic                 ACK_M;
   logic                 CNTCLR;
   logic [N_HW+N_SW-1:0] IP_R;
   logic                 INT_M_R;
   logic [VEC_W-1:0]     INTVEC_M_R;
   logic [CNT_W-1:0]     LOSTCNT_R;

   // Driver side: pipeline / test environment.
   modport master (
      output INTREQN, CFG_EDGE, CP0_IM_W_R, IEC_W_R, CP0_JCTRLDM_M_R,
             CLMI_RHOLD, SWSET_W, SWCLR_W, ACK_M, CNTCLR,
      input  IP_R, INT_M_R, INTVEC_M_R, LOSTCNT_R
   );

   // Controller side.
   modport slave (
      input  INTREQN, CFG_EDGE, CP0_IM_W_R, IEC_W_R, CP0_JCTRLDM_M_R,
             CLMI_RHOLD, SWSET_W, SWCLR_W, ACK_M, CNTCLR,
      output IP_R, INT_M_R, INTVEC_M_R, LOSTCNT_R
   );
endinterface

// File: rtl/cop0_intctl.sv
// COP0 interrupt controller: synchronises active-low hardware requests,
// keeps per-line level/edge pending state plus software bits, and
// produces the registered request and priority vector for M stage.
// Edge requests arriving on an already-pending line are counted.
module cop0_intctl #(
   parameter int N_HW        = 6,
   parameter int N_SW        = 2,
   parameter int SYNC_STAGES = 2,
   parameter int VEC_W       = 3,
   parameter int CNT_W       = 8
) (
   input  logic          SYSCLK,
   input  logic          RESET1,
   cop0_intctl_if.slave  bus
);
   localparam int N_TOT = N_HW + N_SW;

   logic [N_HW-1:0]  sync_q [SYNC_STAGES];
   logic [N_HW-1:0]  req_d_q;
   logic [N_HW-1:0]  req_s;
   logic [N_HW-1:0]  rise;
   logic [N_HW-1:0]  lost;
   logic [N_TOT-1:0] ip_q, ip_d;
   logic [N_TOT-1:0] clr;
   logic [N_TOT-1:0] masked;
   logic             int_q, int_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   cnt_sum;
   logic             ack;

   assign req_s  = sync_q[SYNC_STAGES-1];
   assign rise   = req_s & ~req_d_q;
   // An acknowledge only counts when a request was actually presented and
   // the pipeline is not holding.
   assign ack    = bus.ACK_M & int_q & ~bus.CLMI_RHOLD;
   assign clr    = ack ? (N_TOT'(1) << vec_q) : '0;
   assign masked = ip_q & bus.CP0_IM_W_R;

   // Next pending vector and lost-edge detection per line.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
      ip_d = '0;
      lost = '0;
      for (int i = 0; i < N_HW; i++) begin
         if (bus.CFG_EDGE[i]) begin
            // A rise coinciding with a matching clear keeps the bit set.
            ip_d[N_SW+i] = rise[i] | (ip_q[N_SW+i] & ~clr[N_SW+i]);
            lost[i]      = rise[i] & ip_q[N_SW+i] & ~clr[N_SW+i];
         end else begin
            ip_d[N_SW+i] = req_s[i];
         end
      end
      // Set dominates both the software clear and an acknowledge.
      ip_d[N_SW-1:0] = bus.SWSET_W | (ip_q[N_SW-1:0] & ~bus.SWCLR_W & ~clr[N_SW-1:0]);
   end

   // Saturating lost-edge counter, clear taking priority.
   always_comb begin
      cnt_sum = {1'b0, cnt_q};
      for (int i = 0; i < N_HW; i++) begin
         cnt_sum = cnt_sum + (CNT_W+1)'(lost[i]);
      end
      if (bus.CNTCLR) begin
         cnt_d = '0;
      end else if (cnt_sum[CNT_W]) begin
         cnt_d = '1;
      end else begin
         cnt_d = cnt_sum[CNT_W-1:0];
      end
   end

   // Request and highest-priority vector, frozen while the pipeline holds.
   always_comb begin
      int_d = int_q;
      vec_d = vec_q;
      if (!bus.CLMI_RHOLD) begin
         int_d = bus.IEC_W_R & ~bus.CP0_JCTRLDM_M_R & (|masked);
         vec_d = '0;
         for (int i = 0; i < N_TOT; i++) begin
            if (masked[i]) vec_d = VEC_W'(i);
         end
      end
   end

   // State registers: synchroniser chain, edge history, pending, outputs.
   always_ff @(posedge SYSCLK or posedge RESET1) begin
      if (RESET1) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         req_d_q <= '0;
         ip_q    <= '0;
         int_q   <= 1'b0;
         vec_q   <= '0;
         cnt_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         sync_q[0] <= ~bus.INTREQN;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         req_d_q <= req_s;
         ip_q    <= ip_d;
         int_q   <= int_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.IP_R       = ip_q;
   assign bus.INT_M_R    = int_q;
   assign bus.INTVEC_M_R = vec_q;
   assign bus.LOSTCNT_R  = cnt_q;
endmodule

// File: tb/tb_cop0_intctl.sv
// Directed bench for cop0_intctl: reset, level and edge lines, acknowledge,
// priority/mask/enable gating, lost-edge saturation and pipeline hold.
module tb_cop0_intctl;
   logic SYSCLK = 1'b0;
   logic RESET1 = 1'b1;
   int   errors = 0;
   int   checks = 0;

   cop0_intctl_if #(.N_HW(6), .N_SW(2), .VEC_W(3), .CNT_W(8)) bus ();

   cop0_intctl #(.N_HW(6), .N_SW(2), .SYNC_STAGES(2), .VEC_W(3), .CNT_W(8)) dut (
      .SYSCLK (SYSCLK),
      .RESET1 (RESET1),
      .bus    (bus)
   );

   always #5 SYSCLK = ~SYSCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges; return 1 time unit after the last one.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge SYSCLK);
         #1;
      end
   endtask

   initial begin
      bus.INTREQN         = '1;
      bus.CFG_EDGE        = '0;
      bus.CP0_IM_W_R      = '0;
      bus.IEC_W_R         = 1'b0;
      bus.CP0_JCTRLDM_M_R = 1'b0;
      bus.CLMI_RHOLD      = 1'b0;
      bus.SWSET_W         = '0;
      bus.SWCLR_W         = '0;
      bus.ACK_M           = 1'b0;
      bus.CNTCLR          = 1'b0;
      #12 RESET1 = 1'b0;
      cyc(1);
      check("reset_ip",   bus.IP_R, 32'h00);
      check("reset_int",  bus.INT_M_R, 32'h0);
      check("reset_vec",  bus.INTVEC_M_R, 32'h0);
      check("reset_cnt",  bus.LOSTCNT_R, 32'h00);

      // Mid-cycle reset with line 3 edge-pending.
      bus.CFG_EDGE   = 6'b001000;
      bus.INTREQN[3] = 1'b0;
      cyc(2);
      bus.INTREQN[3] = 1'b1;
      cyc(1);
      check("edge3_pending", bus.IP_R, 32'h20);
      #3 RESET1 = 1'b1;
      #1;
      check("async_reset_ip",  bus.IP_R, 32'h00);
      check("async_reset_int", bus.INT_M_R, 32'h0);
      check("async_reset_vec", bus.INTVEC_M_R, 32'h0);
      #10 RESET1 = 1'b0;
      cyc(5);
      check("post_reset_ip", bus.IP_R, 32'h00);

      // Level line 0.
      bus.CFG_EDGE   = '0;
      bus.CP0_IM_W_R = 8'hFF;
      bus.IEC_W_R    = 1'b1;
      bus.INTREQN[0] = 1'b0;
      cyc(2);
      check("level_not_yet", bus.IP_R, 32'h00);
      cyc(1);
      check("level_ip",     bus.IP_R, 32'h04);
      check("level_int_lag", bus.INT_M_R, 32'h0);
      cyc(1);
      check("level_int", bus.INT_M_R, 32'h1);
      check("level_vec", bus.INTVEC_M_R, 32'h2);
      bus.INTREQN[0] = 1'b1;
      cyc(2);
      check("level_still", bus.IP_R, 32'h04);
      cyc(1);
      check("level_clear", bus.IP_R, 32'h00);
      cyc(1);
      check("level_int_off", bus.INT_M_R, 32'h0);

      // Edge line 5 and acknowledge.
      bus.CFG_EDGE   = 6'b100000;
      bus.INTREQN[5] = 1'b0;
      cyc(2);
      bus.INTREQN[5] = 1'b1;
      cyc(1);
      check("edge_ip", bus.IP_R, 32'h80);
      cyc(1);
      check("edge_int", bus.INT_M_R, 32'h1);
      check("edge_vec", bus.INTVEC_M_R, 32'h7);
      cyc(3);
      check("edge_sticky", bus.IP_R, 32'h80);
      bus.ACK_M = 1'b1;
      cyc(1);
      bus.ACK_M = 1'b0;
      check("ack_clear_ip", bus.IP_R, 32'h00);
      check("ack_int_lag",  bus.INT_M_R, 32'h1);
      cyc(1);
      check("ack_int_off", bus.INT_M_R, 32'h0);

      // Rise coinciding with a matching acknowledge.
      bus.INTREQN[5] = 1'b0;
      cyc(2);
      bus.INTREQN[5] = 1'b1;
      cyc(1);
      cyc(1);
      check("rise2_int", bus.INT_M_R, 32'h1);
      bus.INTREQN[5] = 1'b0;
      cyc(2);
      bus.INTREQN[5] = 1'b1;
      bus.ACK_M      = 1'b1;
      cyc(1);
      bus.ACK_M = 1'b0;
      check("rise_ack_ip",  bus.IP_R, 32'h80);
      check("rise_ack_cnt", bus.LOSTCNT_R, 32'h00);
      bus.ACK_M = 1'b1;
      cyc(1);
      bus.ACK_M = 1'b0;
      check("final_ack_ip", bus.IP_R, 32'h00);
      cyc(2);

      // Priority, mask and enable gating.
      bus.SWSET_W    = 2'b01;
      bus.INTREQN[1] = 1'b0;
      cyc(1);
      bus.SWSET_W = 2'b00;
      cyc(2);
      check("prio_ip", bus.IP_R, 32'h09);
      cyc(1);
      check("prio_vec", bus.INTVEC_M_R, 32'h3);
      check("prio_int", bus.INT_M_R, 32'h1);
      bus.CP0_IM_W_R = 8'hF7;
      cyc(1);
      check("mask_vec", bus.INTVEC_M_R, 32'h0);
      check("mask_int", bus.INT_M_R, 32'h1);
      bus.CP0_IM_W_R = 8'hFF;
      bus.IEC_W_R    = 1'b0;
      cyc(1);
      check("iec_int", bus.INT_M_R, 32'h0);
      check("iec_ip",  bus.IP_R, 32'h09);
      bus.IEC_W_R         = 1'b1;
      bus.CP0_JCTRLDM_M_R = 1'b1;
      cyc(1);
      check("dm_int", bus.INT_M_R, 32'h0);
      check("dm_ip",  bus.IP_R, 32'h09);
      bus.CP0_JCTRLDM_M_R = 1'b0;
      cyc(1);
      check("reen_int", bus.INT_M_R, 32'h1);
      check("reen_vec", bus.INTVEC_M_R, 32'h3);
      bus.SWSET_W = 2'b10;
      bus.SWCLR_W = 2'b10;
      cyc(1);
      check("sw_set_wins", bus.IP_R, 32'h0B);
      bus.SWSET_W    = 2'b00;
      bus.SWCLR_W    = 2'b11;
      bus.INTREQN[1] = 1'b1;
      cyc(1);
      bus.SWCLR_W = 2'b00;
      check("sw_clear", bus.IP_R, 32'h08);
      cyc(2);
      check("prio_cleanup_ip", bus.IP_R, 32'h00);
      cyc(2);

      // Lost edges and saturation on edge line 2.
      bus.CFG_EDGE = 6'b100100;
      for (int k = 0; k < 10; k++) begin
         bus.INTREQN[2] = 1'b0;
         cyc(2);
         bus.INTREQN[2] = 1'b1;
         cyc(2);
      end
      cyc(2);
      check("lost_9",     bus.LOSTCNT_R, 32'd9);
      check("lost_ip",    bus.IP_R, 32'h10);
      for (int k = 0; k < 250; k++) begin
         bus.INTREQN[2] = 1'b0;
         cyc(2);
         bus.INTREQN[2] = 1'b1;
         cyc(2);
      end
      cyc(2);
      check("lost_sat", bus.LOSTCNT_R, 32'd255);
      bus.INTREQN[2] = 1'b0;
      cyc(2);
      bus.INTREQN[2] = 1'b1;
      bus.CNTCLR     = 1'b1;
      cyc(1);
      bus.CNTCLR = 1'b0;
      check("cntclr_prio", bus.LOSTCNT_R, 32'd0);
      bus.INTREQN[2] = 1'b0;
      cyc(2);
      bus.INTREQN[2] = 1'b1;
      cyc(2);
      check("lost_after_clr", bus.LOSTCNT_R, 32'd1);

      // Hold: request at vector 4, line 5 becomes pending underneath.
      check("hold_pre_vec", bus.INTVEC_M_R, 32'h4);
      bus.CLMI_RHOLD = 1'b1;
      bus.INTREQN[5] = 1'b0;
      cyc(2);
      bus.INTREQN[5] = 1'b1;
      cyc(1);
      check("hold_ip", bus.IP_R, 32'h90);
      cyc(1);
      check("hold_vec", bus.INTVEC_M_R, 32'h4);
      check("hold_int", bus.INT_M_R, 32'h1);
      bus.ACK_M = 1'b1;
      cyc(1);
      bus.ACK_M = 1'b0;
      check("hold_ack_ignored", bus.IP_R, 32'h90);
      check("hold_vec2", bus.INTVEC_M_R, 32'h4);
      bus.CLMI_RHOLD = 1'b0;
      cyc(1);
      check("release_vec", bus.INTVEC_M_R, 32'h7);
      check("release_int", bus.INT_M_R, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
